// File: rtl/logic_op_scheduler_if.sv
// Request/result handshake bundle for logic_op_scheduler.
// master = requesters + result sink, slave = the scheduler.
interface logic_op_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]     req_op;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_data;
    logic [IDW-1:0]           res_id;

    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_data, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_data, res_id
    );
endinterface

// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one AND/OR unit (bitwise and logical) between
// NUM_REQ requesters; one operation in flight, 3-cycle accept-to-accept.
module logic_op_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    logic_op_scheduler_if.slave  bus,
    output logic                 busy
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   gnt_q;
    logic             any_req;
    logic             accept;
    logic             res_fire;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt     = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr) + int'(k)) % NUM_REQ);
            if (!any_req && bus.req_valid[cand]) begin
                any_req = 1'b1;
                gnt     = cand;
            end
        end
    end

    // rst_n gating keeps req_ready low while reset is held with requests pending.
    assign accept   = rst_n && (state == IDLE) && any_req;
    assign res_fire = (state == HOLD) && bus.res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = HOLD;
            HOLD:    if (res_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[gnt] = 1'b1;
        busy = (state != IDLE);
    end

    always_comb begin
        result = '0;
        case (op_q)
            2'b00: result    = a_q & b_q;
            2'b01: result    = a_q | b_q;
            2'b10: result[0] = (|a_q) && (|b_q);
            2'b11: result[0] = (|a_q) || (|b_q);
            default: result  = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            gnt_q         <= '0;
            rr_ptr        <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= '0;
        end else begin
            if (accept) begin
                a_q   <= bus.req_a[gnt*WIDTH +: WIDTH];
                b_q   <= bus.req_b[gnt*WIDTH +: WIDTH];
                op_q  <= bus.req_op[gnt*2 +: 2];
                gnt_q <= gnt;
            end
            if (state == EXEC) begin
                bus.res_data  <= result;
                bus.res_id    <= gnt_q;
                bus.res_valid <= 1'b1;
            end
            if (res_fire) begin
                bus.res_valid <= 1'b0;
                rr_ptr        <= (gnt_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            end
        end
    end
endmodule

// File: doc/logic_op_scheduler.md
Name: logic_op_scheduler

Overview:
- Shares one AND/OR operator unit between NUM_REQ requesters.
- Supported operations: bitwise AND, bitwise OR, logical AND, logical OR.
- Round-robin arbitration; valid/ready handshakes on both the request side and the result side.
- Sits in front of the bitwise/logical compute path. Only one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters; must be ≥2.
- WIDTH, 2, operand and result width in bits.
- IDW, $clog2(NUM_REQ), requester-ID width (derived; do not override).

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand a; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand b; same slicing as req_a.
- req_op  input  NUM_REQ*2  opcode; requester i uses slice [i*2 +: 2]. 00 = bitwise AND, 01 = bitwise OR, 10 = logical AND, 11 = logical OR.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts result.
- res_data  output  WIDTH  result.
- res_id  output  IDW  index of the requester that issued this result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low): state = IDLE, rr_ptr = 0, res_valid = 0, res_data = 0, res_id = 0, req_ready = 0, busy = 0. Any in-flight operation is discarded; nothing is replayed after reset.
- States: IDLE, EXEC, HOLD.
- IDLE:
  - Grant goes to the first i with req_valid[i] = 1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[grant] is asserted combinationally in the same cycle (IDLE only).
  - The handshake is the cycle where valid and ready are both high. On it, capture a, b, op and grant index, then go to EXEC.
  - No valid requests: stay in IDLE, req_ready = 0.
- EXEC (one cycle):
  - Compute the result from the captured operands.
  - Bitwise ops: result is the full WIDTH.
  - Logical ops: result = {(WIDTH-1)'b0, (|a) op (|b)}.
  - Register res_data and res_id, set res_valid = 1, go to HOLD.
- HOLD:
  - res_valid, res_data and res_id are held stable until res_ready = 1.
  - On that handshake: res_valid = 0, rr_ptr = (grant + 1) mod NUM_REQ, go to IDLE.
- req_ready is 0 in EXEC and HOLD. Requesters keep valid asserted and operands stable until they are accepted.
- Latency: accept in cycle T, res_valid high in T+2 (if res_ready is held high, the result handshake also occurs in T+2). Next accept is possible in T+3, so maximum throughput is 1 operation per 3 cycles.
- Fairness: once requester k is served, it has the lowest priority in the next arbitration. Every continuously requesting requester is served within NUM_REQ grants.
- rr_ptr wrap: a grant of NUM_REQ-1 sets rr_ptr to 0.
- A requester that drops req_valid while in IDLE before the handshake loses no state; it is simply not granted.
- res_ready asserted while res_valid = 0 is ignored.
- Opcode semantics:
  - 2'b01 with 2'b10, bitwise AND = 2'b00; logical AND = 2'b01.
  - 2'b00 with 2'b11, logical OR = 2'b01; logical AND = 2'b00.

Test Plan:
- Reset mid-HOLD:
  - Stimulus: req 0 issues a=11, b=01, op=00 and is accepted. Assert rst_n = 0 while in HOLD with res_ready = 0.
  - Response: res_valid = 0 and busy = 0 immediately (async). After release, the next grant searches from index 0.
- Single request, full latency check:
  - Stimulus: req 2 with a=11, b=10, op=00; res_ready = 1.
  - Response: req_ready = 0100 in cycle T; res_valid = 1, res_data = 10, res_id = 2 in T+2; busy low in T+3.
- Round-robin order with all requesters contending:
  - Stimulus: all four req_valid held high.
  - Response: grant order 0, 1, 2, 3, 0, … with res_id following the same sequence. Each request completes in 3 cycles.
- Result backpressure:
  - Stimulus: req 1 with a=00, b=11, op=11; res_ready held 0 for 5 cycles.
  - Response: res_data = 01 and res_id = 1 remain stable; req_ready stays 0000 throughout. Handshake completes on the first cycle res_ready = 1.
- Logical vs bitwise on the same operands:
  - Stimulus: a=01, b=10 issued with op=00, then 10, then 01, then 11.
  - Response: results 00, 01, 11, 01 respectively.
- Pointer wrap:
  - Stimulus: only req 3 valid, then only req 0 and req 3 valid.
  - Response: req 3 is served first; in the next arbitration req 0 wins over req 3.
